// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the main-memory controller: bus geometry macros,
// controller state encoding and the READ/WRITE transfer direction.
`ifndef ADDR_BUS_WIDTH
`define ADDR_BUS_WIDTH 32
`endif
`ifndef LINE_SIZE
`define LINE_SIZE 16
`endif

package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    W_DATA,
    W_WAIT,
    R_WAIT
  } mem_state_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } hwrite_t;

  localparam int unsigned LINE_BITS = `LINE_SIZE * 8;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mem_line_ram.sv
// Single-port line store: synchronous write, combinational read.
module mem_line_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 128
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/mem_ctrl.sv
// Main-memory slave: one line-wide access at a time with fixed read/write
// latency; hready is the only flow control.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned RD_LAT    = 4,
  parameter int unsigned WR_LAT    = 2,
  parameter int unsigned INIT_ZERO = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       hreq,
  input  logic [`ADDR_BUS_WIDTH-1:0] haddr,
  input  hwrite_t                    hwrite,
  input  logic [LINE_BITS-1:0]       hwdata,
  output logic                       hready,
  output logic [LINE_BITS-1:0]       hrdata,
  output logic [15:0]                rd_cnt,
  output logic [15:0]                wr_cnt
);

  localparam int unsigned IW      = $clog2(DEPTH);
  localparam int unsigned OFF     = $clog2(`LINE_SIZE);
  localparam int unsigned LAT_MAX = max_u(RD_LAT, WR_LAT);
  localparam int unsigned LW      = $clog2(LAT_MAX + 1);
  // Wait states span LAT-1 cycles; the counter runs from LAT-2 down to 0.
  localparam int unsigned RD_WAIT = (RD_LAT > 1) ? RD_LAT - 2 : 0;
  localparam int unsigned WR_WAIT = (WR_LAT > 1) ? WR_LAT - 2 : 0;

  mem_state_t           state, state_n;
  logic [IW-1:0]        idx_q, idx_n;
  logic [LW-1:0]        lat_cnt, lat_n;
  logic                 ram_we;
  logic [IW-1:0]        ram_idx;
  logic [LINE_BITS-1:0] ram_wdata, ram_rdata;
  logic                 rd_done, wr_done;

  mem_line_ram #(
    .DEPTH (DEPTH),
    .WIDTH (LINE_BITS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .idx   (ram_idx),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_n   = state;
    idx_n     = idx_q;
    lat_n     = lat_cnt;
    ram_we    = 1'b0;
    ram_idx   = idx_q;
    ram_wdata = hwdata;
    rd_done   = 1'b0;
    wr_done   = 1'b0;
    hready    = (state == IDLE);
    unique case (state)
      INIT: begin
        // idx_q doubles as the clear pointer while initialising
        ram_we    = 1'b1;
        ram_wdata = '0;
        idx_n     = idx_q + IW'(1);
        if (idx_q == IW'(DEPTH - 1)) state_n = IDLE;
      end
      IDLE: begin
        ram_idx = haddr[OFF +: IW];
        if (hreq) begin
          idx_n = haddr[OFF +: IW];
          if (hwrite == WRITE) begin
            state_n = W_DATA;
          end else if (RD_LAT == 1) begin
            rd_done = 1'b1;
          end else begin
            state_n = R_WAIT;
            lat_n   = LW'(RD_WAIT);
          end
        end
      end
      W_DATA: begin
        ram_we  = 1'b1;
        wr_done = 1'b1;
        if (WR_LAT == 1) begin
          state_n = IDLE;
        end else begin
          state_n = W_WAIT;
          lat_n   = LW'(WR_WAIT);
        end
      end
      W_WAIT: begin
        if (lat_cnt == '0) state_n = IDLE;
        else lat_n = lat_cnt - LW'(1);
      end
      R_WAIT: begin
        if (lat_cnt == '0) begin
          rd_done = 1'b1;
          state_n = IDLE;
        end else begin
          lat_n = lat_cnt - LW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    // A reset landing on the data phase must leave the array untouched.
    if (rst) ram_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= (INIT_ZERO != 0) ? INIT : IDLE;
      idx_q   <= '0;
      lat_cnt <= '0;
      hrdata  <= '0;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
    end else begin
      state   <= state_n;
      idx_q   <= idx_n;
      lat_cnt <= lat_n;
      if (rd_done) begin
        hrdata <= ram_rdata;
        rd_cnt <= rd_cnt + 16'd1;
      end
      if (wr_done) wr_cnt <= wr_cnt + 16'd1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && hreq && hready && $isunknown(haddr))
      $error("mem_ctrl: X on haddr during address phase");
  end
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: an INIT_ZERO=1 instance for the main vectors
// and a small INIT_ZERO=0 instance for the reset-abort scenario.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int unsigned RD_LAT = 4;
  localparam int unsigned WR_LAT = 2;
  localparam int unsigned DEPTH0 = 256;
  localparam int unsigned DEPTH1 = 16;

  typedef logic [LINE_BITS-1:0] line_t;
  typedef logic [`ADDR_BUS_WIDTH-1:0] addr_t;

  typedef struct {
    hwrite_t     w;
    addr_t       a;
    line_t       d;
    line_t       exp;
    logic [15:0] rd;
    logic [15:0] wr;
  } vec_t;

  logic    clk = 1'b0;
  logic    rst0 = 1'b1;
  logic    rst1 = 1'b1;
  logic    hreq = 1'b0;
  addr_t   haddr = '0;
  hwrite_t hwrite = READ;
  line_t   hwdata = '0;

  logic        hready0, hready1;
  line_t       hrdata0, hrdata1;
  logic [15:0] rd0, wr0, rd1, wr1;

  bit          sel = 1'b0;
  logic        hready_s;
  line_t       hrdata_s;
  logic [15:0] rd_s, wr_s;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  assign hready_s = sel ? hready1 : hready0;
  assign hrdata_s = sel ? hrdata1 : hrdata0;
  assign rd_s     = sel ? rd1 : rd0;
  assign wr_s     = sel ? wr1 : wr0;

  always #5 clk = ~clk;

  mem_ctrl #(
    .DEPTH     (DEPTH0),
    .RD_LAT    (RD_LAT),
    .WR_LAT    (WR_LAT),
    .INIT_ZERO (1)
  ) dut0 (
    .clk    (clk),
    .rst    (rst0),
    .hreq   (hreq),
    .haddr  (haddr),
    .hwrite (hwrite),
    .hwdata (hwdata),
    .hready (hready0),
    .hrdata (hrdata0),
    .rd_cnt (rd0),
    .wr_cnt (wr0)
  );

  mem_ctrl #(
    .DEPTH     (DEPTH1),
    .RD_LAT    (RD_LAT),
    .WR_LAT    (WR_LAT),
    .INIT_ZERO (0)
  ) dut1 (
    .clk    (clk),
    .rst    (rst1),
    .hreq   (hreq),
    .haddr  (haddr),
    .hwrite (hwrite),
    .hwdata (hwdata),
    .hready (hready1),
    .hrdata (hrdata1),
    .rd_cnt (rd1),
    .wr_cnt (wr1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input line_t act, input line_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Full transaction starting in the accept cycle A; returns in the cycle
  // hready is high again (A+RD_LAT for reads, A+WR_LAT+1 for writes).
  task automatic access(input string tag, input hwrite_t w, input addr_t a,
                        input line_t d, input line_t exp);
    check({tag, " accept_ready"}, line_t'(hready_s), line_t'(1));
    hreq   = 1'b1;
    hwrite = w;
    haddr  = a;
    hwdata = ~d;
    tick();
    hreq   = 1'b0;
    hwrite = (w == WRITE) ? READ : WRITE;
    haddr  = a ^ addr_t'(32'h40);
    if (w == WRITE) begin
      hwdata = d;
      for (int unsigned k = 1; k <= WR_LAT; k++) begin
        check({tag, " wr_busy"}, line_t'(hready_s), line_t'(0));
        tick();
        hwdata = ~d;
      end
      check({tag, " wr_ready"}, line_t'(hready_s), line_t'(1));
    end else begin
      for (int unsigned k = 1; k < RD_LAT; k++) begin
        check({tag, " rd_busy"}, line_t'(hready_s), line_t'(0));
        tick();
      end
      check({tag, " rd_ready"}, line_t'(hready_s), line_t'(1));
      check({tag, " rd_data"}, hrdata_s, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin
    vec_t        tbl[10];
    line_t       pat_a5, pat_d, pat_e, pat_p, pat_q;
    int unsigned cnt;

    pat_a5 = {16{8'hA5}};
    pat_d  = 128'h0123456789ABCDEF_FEDCBA9876543210;
    pat_e  = {4{32'hDEADBEEF}};
    pat_p  = {8{16'h5A3C}};
    pat_q  = {8{16'hC3E1}};

    tbl[0] = '{READ,  32'h0000_0040, '0,     '0,     16'd1, 16'd0};
    tbl[1] = '{WRITE, 32'h0000_0080, pat_a5, '0,     16'd1, 16'd1};
    tbl[2] = '{READ,  32'h0000_0080, '0,     pat_a5, 16'd2, 16'd1};
    tbl[3] = '{WRITE, 32'h0000_0010, pat_d,  '0,     16'd2, 16'd2};
    tbl[4] = '{READ,  32'h0000_1010, '0,     pat_d,  16'd3, 16'd2};
    tbl[5] = '{READ,  32'h0000_0010, '0,     pat_d,  16'd4, 16'd2};
    tbl[6] = '{WRITE, 32'h0000_0FF0, pat_e,  '0,     16'd4, 16'd3};
    tbl[7] = '{READ,  32'h0000_0FF0, '0,     pat_e,  16'd5, 16'd3};
    tbl[8] = '{READ,  32'h0000_0000, '0,     '0,     16'd6, 16'd3};
    tbl[9] = '{READ,  32'hF000_0FF0, '0,     pat_e,  16'd7, 16'd3};

    // Reset state of the INIT_ZERO=1 instance
    repeat (3) tick();
    check("rst hready", line_t'(hready0), line_t'(0));
    check("rst hrdata", hrdata0, '0);
    check("rst rd_cnt", line_t'(rd0), '0);
    check("rst wr_cnt", line_t'(wr0), '0);

    rst0 = 1'b0;
    cnt  = 0;
    while (hready0 == 1'b0 && cnt < DEPTH0 + 8) begin
      cnt++;
      tick();
    end
    check("init_cycles", line_t'(cnt), line_t'(DEPTH0));

    foreach (tbl[i]) begin
      access($sformatf("vec%0d", i), tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].exp);
      check($sformatf("vec%0d rd_cnt", i), line_t'(rd_s), line_t'(tbl[i].rd));
      check($sformatf("vec%0d wr_cnt", i), line_t'(wr_s), line_t'(tbl[i].wr));
    end

    // Back-to-back reads with hreq held high through the busy cycles
    check("b2b accept_ready", line_t'(hready0), line_t'(1));
    hreq   = 1'b1;
    hwrite = READ;
    haddr  = 32'h80;
    tick();
    for (int unsigned k = 1; k < RD_LAT; k++) begin
      check("b2b busy1", line_t'(hready0), line_t'(0));
      tick();
    end
    check("b2b ready1", line_t'(hready0), line_t'(1));
    check("b2b data1", hrdata0, pat_a5);
    check("b2b rd_cnt1", line_t'(rd0), line_t'(8));
    haddr = 32'h1010;
    tick();
    hreq = 1'b0;
    for (int unsigned k = 1; k < RD_LAT; k++) begin
      check("b2b busy2", line_t'(hready0), line_t'(0));
      tick();
    end
    check("b2b ready2", line_t'(hready0), line_t'(1));
    check("b2b data2", hrdata0, pat_d);
    check("b2b rd_cnt2", line_t'(rd0), line_t'(9));
    repeat (4) tick();
    check("idle rd_cnt", line_t'(rd0), line_t'(9));
    check("idle wr_cnt", line_t'(wr0), line_t'(3));
    check("idle hready", line_t'(hready0), line_t'(1));

    // INIT_ZERO=0 instance: reset during a write's address-to-data gap
    sel = 1'b1;
    check("nz rst hready", line_t'(hready1), line_t'(1));
    check("nz rst hrdata", hrdata1, '0);
    check("nz rst rd_cnt", line_t'(rd1), '0);
    rst1 = 1'b0;
    tick();
    access("nz wr_p", WRITE, 32'h20, pat_p, '0);
    check("nz wr_cnt1", line_t'(wr1), line_t'(1));

    hreq   = 1'b1;
    hwrite = WRITE;
    haddr  = 32'h20;
    hwdata = ~pat_q;
    tick();
    hreq   = 1'b0;
    rst1   = 1'b1;
    hwdata = pat_q;
    tick();
    rst1 = 1'b0;
    check("abort hready", line_t'(hready1), line_t'(1));
    check("abort rd_cnt", line_t'(rd1), '0);
    check("abort wr_cnt", line_t'(wr1), '0);
    tick();
    check("abort hready2", line_t'(hready1), line_t'(1));
    access("nz rd_old", READ, 32'h20, '0, pat_p);
    check("nz rd_cnt1", line_t'(rd1), line_t'(1));
    access("nz rd_alias", READ, 32'h120, '0, pat_p);
    check("nz rd_cnt2", line_t'(rd1), line_t'(2));
    check("nz wr_cnt0", line_t'(wr1), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
